// File: rtl/axis_mux_serializer_shim.sv
// axis_mux_serializer_shim: round-robin AXIS packet mux that serializes beats into credit-flow NoC flits.
// Define AXIS_MUX_SHIM_STATS_EN to add per-channel packet counters and a sticky credit-error flag.
module axis_mux_serializer_shim #(
    parameter int NUM_CHANNELS         = 4,
    parameter int TDATA_WIDTH          = 512,
    parameter int TID_WIDTH            = 2,
    parameter int TDEST_WIDTH          = 4,
    parameter int SERIALIZATION_FACTOR = 4,
    parameter int FLIT_BUFFER_DEPTH    = 4
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [NUM_CHANNELS-1:0]                      axis_in_tvalid,
    output logic [NUM_CHANNELS-1:0]                      axis_in_tready,
    input  logic [NUM_CHANNELS-1:0][TDATA_WIDTH-1:0]     axis_in_tdata,
    input  logic [NUM_CHANNELS-1:0]                      axis_in_tlast,
    input  logic [NUM_CHANNELS-1:0][TID_WIDTH-1:0]       axis_in_tid,
    input  logic [NUM_CHANNELS-1:0][TDEST_WIDTH-1:0]     axis_in_tdest,
    output logic [TDATA_WIDTH/SERIALIZATION_FACTOR-1:0]  data_out,
    output logic [TID_WIDTH+TDEST_WIDTH-1:0]             dest_out,
    output logic                                         is_tail_out,
    output logic                                         send_out,
`ifdef AXIS_MUX_SHIM_STATS_EN
    output logic [NUM_CHANNELS-1:0][31:0]                stat_pkts,
    output logic                                         stat_credit_err,
`endif
    input  logic                                         credit_in
);
    localparam int FW = TDATA_WIDTH / SERIALIZATION_FACTOR;
    localparam int CW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
    localparam int KW = SERIALIZATION_FACTOR > 1 ? $clog2(SERIALIZATION_FACTOR) : 1;
    localparam int RW = $clog2(FLIT_BUFFER_DEPTH + 1);
    localparam logic [KW-1:0] KLAST = KW'(SERIALIZATION_FACTOR - 1);
    localparam logic [CW-1:0] CLAST = CW'(NUM_CHANNELS - 1);
    localparam logic [RW-1:0] FULL  = RW'(FLIT_BUFFER_DEPTH);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                            state;
    logic [CW-1:0]                     ptr, gnt, sel, cur, c_idx;
    logic [TDATA_WIDTH-1:0]            hold_data;
    logic [TID_WIDTH+TDEST_WIDTH-1:0]  hold_dest;
    logic                              hold_valid, hold_last;
    logic [KW-1:0]                     idx;
    logic [RW-1:0]                     credits;
    logic                              any, send, final_send, slot_free, accept, acc_last, cred_ovf;

    function automatic logic [CW-1:0] nxt(input logic [CW-1:0] x);
        return (x == CLAST) ? '0 : x + 1'b1;
    endfunction

    // Descending scan so the channel closest above the pointer wins.
    always_comb begin
        sel = ptr;
        c_idx = ptr;
        for (int j = NUM_CHANNELS - 1; j >= 0; j--) begin
            c_idx = CW'((int'(ptr) + j) % NUM_CHANNELS);
            if (axis_in_tvalid[c_idx]) sel = c_idx;
        end
    end

    assign any        = |axis_in_tvalid;
    assign cur        = (state == BUSY) ? gnt : sel;
    assign send       = hold_valid && (credits != '0);
    assign final_send = send && (idx == KLAST);
    assign slot_free  = !hold_valid || final_send;
    assign accept     = axis_in_tvalid[cur] && axis_in_tready[cur];
    assign acc_last   = accept && axis_in_tlast[cur];
    assign cred_ovf   = credit_in && (credits == FULL) && !send;

    always_comb begin
        axis_in_tready = '0;
        axis_in_tready[cur] = slot_free && (state == BUSY || any);
    end

    assign send_out    = send;
    assign data_out    = hold_data[idx*FW +: FW];
    assign is_tail_out = send && hold_last && (idx == KLAST);
    assign dest_out    = hold_dest;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            gnt        <= '0;
            hold_valid <= 1'b0;
            hold_last  <= 1'b0;
            hold_data  <= '0;
            hold_dest  <= '0;
            idx        <= '0;
            credits    <= FULL;
        end else begin
            credits <= credits - RW'(send) + RW'(credit_in && !cred_ovf);
            if (accept) begin
                hold_valid <= 1'b1;
                hold_last  <= axis_in_tlast[cur];
                hold_data  <= axis_in_tdata[cur];
                hold_dest  <= {axis_in_tid[cur], axis_in_tdest[cur]};
                idx        <= '0;
            end else if (final_send) begin
                hold_valid <= 1'b0;
                idx        <= '0;
            end else if (send) begin
                idx <= idx + 1'b1;
            end
            if (state == IDLE && any) begin
                gnt   <= sel;
                state <= acc_last ? IDLE : BUSY;
                ptr   <= acc_last ? nxt(sel) : ptr;
            end else if (state == BUSY && acc_last) begin
                state <= IDLE;
                ptr   <= nxt(gnt);
            end
        end
    end

`ifdef AXIS_MUX_SHIM_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_pkts       <= '0;
            stat_credit_err <= 1'b0;
        end else begin
            if (acc_last) stat_pkts[cur] <= stat_pkts[cur] + 32'd1;
            if (cred_ovf) stat_credit_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_mux_serializer_shim.sv
// tb_axis_mux_serializer_shim: directed-vector bench for the AXIS mux serializer shim.
module tb_axis_mux_serializer_shim;
    localparam int N  = 4;
    localparam int TW = 512;
    localparam int FW = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]          tvalid, tready, tlast;
    logic [N-1:0][TW-1:0]  tdata;
    logic [N-1:0][1:0]     tid;
    logic [N-1:0][3:0]     tdest;
    logic [FW-1:0]         data_out;
    logic [5:0]            dest_out;
    logic                  is_tail_out, send_out, credit_in;
`ifdef AXIS_MUX_SHIM_STATS_EN
    logic [N-1:0][31:0]    stat_pkts;
    logic                  stat_credit_err;
`endif

    int nvec = 0;
    int nerr = 0;
    logic [N-1:0] hs;
    int left[N];
    int bidx[N];
    logic [FW-1:0] f2[4];

    axis_mux_serializer_shim dut (
        .clk(clk),
        .rst_n(rst_n),
        .axis_in_tvalid(tvalid),
        .axis_in_tready(tready),
        .axis_in_tdata(tdata),
        .axis_in_tlast(tlast),
        .axis_in_tid(tid),
        .axis_in_tdest(tdest),
        .data_out(data_out),
        .dest_out(dest_out),
        .is_tail_out(is_tail_out),
        .send_out(send_out),
`ifdef AXIS_MUX_SHIM_STATS_EN
        .stat_pkts(stat_pkts),
        .stat_credit_err(stat_credit_err),
`endif
        .credit_in(credit_in)
    );

    task automatic check(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Flit k of beat b on channel c carries c*100 + b*10 + k.
    function automatic logic [TW-1:0] beat_data(input int c, input int b);
        logic [TW-1:0] d = '0;
        for (int k = 0; k < 4; k++) d[k*FW +: FW] = FW'(c*100 + b*10 + k);
        return d;
    endfunction

    task automatic run(input int l0, input int l1, input int l2, input int l3,
                       input int o0, input int o1, input string tag);
        int len[N];
        int ord[2];
        int oi = 0, b = 0, k = 0, seen = 0, cyc = 0, total;
        len = '{l0, l1, l2, l3};
        ord = '{o0, o1};
        for (int c = 0; c < N; c++) begin
            left[c] = len[c];
            bidx[c] = 0;
        end
        hs = '0;
        total = 4 * (len[o0] + (o1 >= 0 ? len[o1] : 0));
        while (seen < total && cyc < 200) begin
            @(negedge clk);
            cyc++;
            for (int c = 0; c < N; c++) begin
                if (hs[c]) begin
                    bidx[c]++;
                    left[c]--;
                end
                tvalid[c] = left[c] > 0;
                tdata[c]  = beat_data(c, bidx[c]);
                tlast[c]  = left[c] == 1;
                tid[c]    = 2'(c);
                tdest[c]  = 4'(c + 8);
            end
            credit_in = send_out;
            #1;
            hs = tvalid & tready;
            if (o1 >= 0 && oi == 0 && !(b == len[o0] - 1 && k == 3))
                check({tag, " holdoff tready"}, tready[o1], 1'b0);
            if (send_out) begin
                int ch;
                ch = ord[oi];
                check({tag, " data"}, data_out, FW'(ch*100 + b*10 + k));
                check({tag, " tail"}, is_tail_out, (k == 3 && b == len[ch] - 1));
                check({tag, " dest"}, dest_out, {2'(ch), 4'(ch + 8)});
                seen++;
                k++;
                if (k == 4) begin
                    k = 0;
                    b++;
                    if (b == len[ch]) begin
                        b = 0;
                        oi++;
                    end
                end
            end
        end
        check({tag, " flit count"}, seen, total);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        logic h;
        f2 = '{128'h0f0e0d0c0b0a09080706050403020100, 128'h1f1e1d1c1b1a19181716151413121110,
               128'h2f2e2d2c2b2a29282726252423222120, 128'h3f3e3d3c3b3a39383736353433323130};
        tvalid = '0; tdata = '0; tlast = '0; tid = '0; tdest = '0; credit_in = 1'b0; hs = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst send", send_out, 1'b0);
        check("rst tail", is_tail_out, 1'b0);
        check("rst data", data_out, '0);
        check("rst dest", dest_out, '0);
        check("rst tready", tready, '0);

        // single byte-pattern beat on ch0
        @(negedge clk);
        rst_n = 1'b1;
        tvalid[0] = 1'b1;
        for (int i = 0; i < 64; i++) tdata[0][i*8 +: 8] = 8'(i);
        tlast[0] = 1'b1; tid[0] = 2'd1; tdest[0] = 4'd5;
        #1;
        check("t2 tready", tready, 4'b0001);
        check("t2 pre send", send_out, 1'b0);
        @(negedge clk);
        tvalid[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t2 send", send_out, 1'b1);
            check("t2 data", data_out, f2[k]);
            check("t2 tail", is_tail_out, k == 3);
            check("t2 dest", dest_out, 6'h15);
            @(negedge clk);
        end
        #1;
        check("t2 after", send_out, 1'b0);
        credit_in = 1'b1;
        repeat (4) @(negedge clk);
        credit_in = 1'b0;

        // credit exhaustion on ch2
        tvalid[2] = 1'b1; tdata[2] = beat_data(2, 0); tlast[2] = 1'b0; tid[2] = 2'd2; tdest[2] = 4'd10;
        @(negedge clk);
        tdata[2] = beat_data(2, 1); tlast[2] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t4 send", send_out, 1'b1);
            check("t4 data", data_out, FW'(200 + k));
            check("t4 tready", tready, k == 3 ? 4'b0100 : 4'b0000);
            @(negedge clk);
        end
        tvalid[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t4 stall", send_out, 1'b0);
            @(negedge clk);
        end
        credit_in = 1'b1;
        #1;
        check("t4 pulse", send_out, 1'b0);
        @(negedge clk);
        credit_in = 1'b0;
        #1;
        check("t4 one send", send_out, 1'b1);
        check("t4 one data", data_out, FW'(210));
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t4 one more only", send_out, 1'b0);
            @(negedge clk);
        end

        // credit return coincident with send at credits==1
        credit_in = 1'b1;
        #1;
        check("t5 pre", send_out, 1'b0);
        @(negedge clk);
        for (int k = 1; k < 4; k++) begin
            #1;
            check("t5 no stall", send_out, 1'b1);
            check("t5 data", data_out, FW'(210 + k));
            check("t5 tail", is_tail_out, k == 3);
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        credit_in = 1'b0;

        // reset mid-packet with credits partly consumed
        tvalid[0] = 1'b1; tdata[0] = beat_data(0, 0); tlast[0] = 1'b0; tid[0] = 2'd0; tdest[0] = 4'd8;
        @(negedge clk);
        #1;
        check("t1 flit0", data_out, FW'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        tvalid = '0;
        repeat (2) @(negedge clk);
        #1;
        check("t1 rst send", send_out, 1'b0);
        check("t1 rst tail", is_tail_out, 1'b0);
        check("t1 rst data", data_out, '0);
        check("t1 rst dest", dest_out, '0);
        check("t1 rst tready", tready, '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t1 no stale", send_out, 1'b0);
            @(negedge clk);
        end
        tvalid[0] = 1'b1; tdata[0] = beat_data(0, 0); tlast[0] = 1'b0;
        @(negedge clk);
        tdata[0] = beat_data(0, 1); tlast[0] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (send_out) cnt++;
            h = tvalid[0] && tready[0];
            @(negedge clk);
            if (h) tvalid[0] = 1'b0;
        end
        tvalid[0] = 1'b0;
        check("t1 credits restored", cnt, 4);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // round-robin contention
        run(0, 3, 0, 3, 1, 3, "t3");
        run(1, 1, 0, 0, 0, 1, "t3b");

`ifdef AXIS_MUX_SHIM_STATS_EN
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) run(0, 0, 1, 0, 2, -1, "t6");
        @(negedge clk);
        credit_in = 1'b1;
        @(negedge clk);
        credit_in = 1'b0;
        #1;
        check("t6 pkts2", stat_pkts[2], 32'd5);
        check("t6 pkts0", stat_pkts[0], 32'd0);
        check("t6 err", stat_credit_err, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        check("t6 err sticky", stat_credit_err, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("t6 err rst", stat_credit_err, 1'b0);
        check("t6 pkts rst", stat_pkts[2], 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
